// File: rtl/wb_gpio_debounce_irq.sv
// Wishbone classic slave: GPIO with per-pin output enable, debounced keys with sticky
// press events, and a level interrupt raised by enabled press events.
module wb_gpio_debounce_irq #(
    parameter int GPIO_WIDTH      = 8,
    parameter int KEY_WIDTH       = 2,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    input  logic [KEY_WIDTH-1:0]  key_i,
    output logic [KEY_WIDTH-1:0]  key_state_o,
    output logic                  irq_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic KEY_AL = (KEY_ACTIVE_LOW != 0);
    localparam logic [KEY_WIDTH-1:0] KEY_RELEASED = {KEY_WIDTH{KEY_AL}};

    logic [GPIO_WIDTH-1:0]         gpio_s1_q, gpio_s2_q;
    logic [KEY_WIDTH-1:0]          key_s1_q, key_s2_q;
    logic [KEY_WIDTH-1:0]          stable_q, stable_d;
    logic [KEY_WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [GPIO_WIDTH-1:0]         dout_q, dout_d;
    logic [GPIO_WIDTH-1:0]         dir_q, dir_d;
    logic [KEY_WIDTH-1:0]          key_edge_q, key_edge_d;
    logic [KEY_WIDTH-1:0]          irq_en_q, irq_en_d;
    logic                          ack_q, ack_d;
    logic [31:0]                   dat_q, dat_d;

    logic [KEY_WIDTH-1:0]          key_pressed_s;
    logic [KEY_WIDTH-1:0]          key_set_s;
    logic [KEY_WIDTH-1:0]          w1c_s;
    logic                          access_s;
    logic [2:0]                    reg_sel_s;
    logic [31:0]                   rd_s;
    logic                          unused_s;

    // Byte lanes, sub-word address bits and unused write-data bits are don't-cares.
    assign unused_s      = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};
    assign key_pressed_s = key_s2_q ^ KEY_RELEASED;
    assign access_s      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign reg_sel_s     = wb_adr_i[4:2];

    // Per-key debounce: accept a new level only after it differs for DEBOUNCE_CYCLES edges.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < KEY_WIDTH; k++) begin
            if (key_pressed_s[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
                stable_d[k] = key_pressed_s[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end
        key_set_s = stable_d & ~stable_q;
    end

    // Register writes and read-data mux; a fresh press overrides a same-cycle W1C.
    always_comb begin
        dout_d   = dout_q;
        dir_d    = dir_q;
        irq_en_d = irq_en_q;
        w1c_s    = '0;
        if (access_s && wb_we_i) begin
            case (reg_sel_s)
                3'd0:    dout_d   = wb_dat_i[GPIO_WIDTH-1:0];
                3'd1:    dir_d    = wb_dat_i[GPIO_WIDTH-1:0];
                3'd4:    w1c_s    = wb_dat_i[KEY_WIDTH-1:0];
                3'd5:    irq_en_d = wb_dat_i[KEY_WIDTH-1:0];
                default: w1c_s    = '0;
            endcase
        end else begin
            w1c_s = '0;
        end
        key_edge_d = (key_edge_q & ~w1c_s) | key_set_s;

        rd_s = '0;
        case (reg_sel_s)
            3'd0:    rd_s[GPIO_WIDTH-1:0] = dout_q;
            3'd1:    rd_s[GPIO_WIDTH-1:0] = dir_q;
            3'd2:    rd_s[GPIO_WIDTH-1:0] = gpio_s2_q;
            3'd3:    rd_s[KEY_WIDTH-1:0]  = stable_q;
            3'd4:    rd_s[KEY_WIDTH-1:0]  = key_edge_q;
            3'd5:    rd_s[KEY_WIDTH-1:0]  = irq_en_q;
            default: rd_s = '0;
        endcase

        ack_d = access_s;
        if (access_s && !wb_we_i) begin
            dat_d = rd_s;
        end else begin
            dat_d = '0;
        end
    end

    // Input synchronisers and debounce state; key flops come out of reset at the released level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gpio_s1_q <= '0;
            gpio_s2_q <= '0;
            key_s1_q  <= KEY_RELEASED;
            key_s2_q  <= KEY_RELEASED;
            stable_q  <= '0;
            cnt_q     <= '0;
        end else begin
            gpio_s1_q <= gpio_i;
            gpio_s2_q <= gpio_s1_q;
            key_s1_q  <= key_i;
            key_s2_q  <= key_s1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
        end
    end

    // Bus-visible registers, acknowledge and read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_q     <= '0;
            dir_q      <= '0;
            key_edge_q <= '0;
            irq_en_q   <= '0;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0000_0000;
        end else begin
            dout_q     <= dout_d;
            dir_q      <= dir_d;
            key_edge_q <= key_edge_d;
            irq_en_q   <= irq_en_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign gpio_o      = dout_q;
    assign gpio_oe     = dir_q;
    assign key_state_o = stable_q;
    assign irq_o       = |(key_edge_q & irq_en_q);

endmodule

// File: tb/tb_wb_gpio_debounce_irq.sv
// Scoreboard bench: a cycle reference model pushes expected bus responses; a negedge monitor
// pops them on every ack and also compares the pin-level outputs each cycle.
module tb_wb_gpio_debounce_irq;

    localparam int GW = 8;
    localparam int KW = 2;
    localparam int DC = 4;

    logic          clock;
    logic          reset;
    logic [4:0]    wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
    logic [GW-1:0] gpio_i, gpio_o, gpio_oe;
    logic [KW-1:0] key_i, key_state_o;
    logic          irq_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state (spec-level: registers plus raw sample histories)
    logic [GW-1:0] m_dout = '0, m_dir = '0, g1 = '0, g2 = '0;
    logic [KW-1:0] m_stable = '0, m_edge = '0, m_irqen = '0;
    logic          m_ack = 1'b0;
    logic [KW-1:0] kh [0:DC];

    wb_gpio_debounce_irq #(
        .GPIO_WIDTH(GW), .KEY_WIDTH(KW), .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock(clock), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe),
        .key_i(key_i), .key_state_o(key_state_o), .irq_o(irq_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pressed level = ~key_i; a key's accepted state becomes v once the
    // synchronised samples (two cycles old) have equalled v for DC consecutive edges.
    initial begin
        exp_t e;
        logic          acc, all_eq, v;
        logic [KW-1:0] set;
        for (int i = 0; i <= DC; i++) kh[i] = '0;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_dout = '0; m_dir = '0; m_stable = '0; m_edge = '0; m_irqen = '0;
                m_ack = 1'b0; g1 = '0; g2 = '0;
                for (int i = 0; i <= DC; i++) kh[i] = '0;
                sb_q.delete();
            end else begin
                acc = wb_cyc_i && wb_stb_i && !m_ack;
                if (acc) begin
                    e.is_read = !wb_we_i;
                    case (wb_adr_i[4:2])
                        3'd0:    e.data = 32'(m_dout);
                        3'd1:    e.data = 32'(m_dir);
                        3'd2:    e.data = 32'(g2);
                        3'd3:    e.data = 32'(m_stable);
                        3'd4:    e.data = 32'(m_edge);
                        3'd5:    e.data = 32'(m_irqen);
                        default: e.data = 32'h0;
                    endcase
                    sb_q.push_back(e);
                end
                set = '0;
                for (int k = 0; k < KW; k++) begin
                    v = kh[1][k];
                    all_eq = 1'b1;
                    for (int i = 1; i <= DC; i++) if (kh[i][k] != v) all_eq = 1'b0;
                    if (all_eq && v != m_stable[k]) begin
                        m_stable[k] = v;
                        if (v) set[k] = 1'b1;
                    end
                end
                if (acc && wb_we_i) begin
                    case (wb_adr_i[4:2])
                        3'd0:    m_dout  = wb_dat_i[GW-1:0];
                        3'd1:    m_dir   = wb_dat_i[GW-1:0];
                        3'd4:    m_edge  = m_edge & ~wb_dat_i[KW-1:0];
                        3'd5:    m_irqen = wb_dat_i[KW-1:0];
                        default: ;
                    endcase
                end
                m_edge = m_edge | set;
                m_ack  = acc;
                for (int i = DC; i >= 1; i--) kh[i] = kh[i-1];
                kh[0] = ~key_i;
                g2 = g1;
                g1 = gpio_i;
            end
        end
    end

    // Monitor: pops one expectation per ack, and compares pin outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            chk("ack", 32'(wb_ack_o), 32'(m_ack));
            if (wb_ack_o) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_read) chk("rdata", wb_dat_o, e.data);
                end
            end else begin
                chk("dat_idle", wb_dat_o, 32'h0);
            end
            chk("gpio_o", 32'(gpio_o), 32'(m_dout));
            chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
            chk("key_state", 32'(key_state_o), 32'(m_stable));
            chk("irq", 32'(irq_o), 32'(|(m_edge & m_irqen)));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One classic access issued just after a rising edge; ack expected at the second negedge.
    task automatic bus(input bit we, input logic [4:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd);
        int n = 0;
        bit got = 1'b0;
        rd = 32'h0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wd;
        while (!got && n < 4) begin
            @(negedge clock);
            n++;
            if (wb_ack_o) begin
                got = 1'b1;
                rd  = wb_dat_o;
            end
        end
        chk("ack_latency", 32'(n), 32'd2);
        @(posedge clock);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] wd);
        logic [31:0] d;
        bus(1'b1, adr, wd, d);
    endtask

    task automatic rd_chk(input logic [4:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] d;
        bus(1'b0, adr, 32'h0, d);
        chk(name, d, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;
        reset = 1'b1;
        wb_adr_i = 5'd0; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        gpio_i = '0; key_i = '1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        step(1);

        chk("rst_gpio_o", 32'(gpio_o), 32'h0);
        chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        chk("rst_key_state", 32'(key_state_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        rd_chk(5'h0C, 32'h0, "rd_key_state_rst");
        rd_chk(5'h10, 32'h0, "rd_key_edge_rst");

        wr(5'h04, 32'h0000_00F0);
        wr(5'h00, 32'h0000_00A5);
        chk("dir_pins", 32'(gpio_oe), 32'hF0);
        chk("dout_pins", 32'(gpio_o), 32'hA5);
        rd_chk(5'h04, 32'hF0, "rd_dir");
        rd_chk(5'h03, 32'hA5, "rd_dout_lowbits");

        gpio_i = 8'h3C;
        step(2);
        rd_chk(5'h08, 32'h3C, "rd_data_in");
        rd_chk(5'h18, 32'h0, "rd_unmapped6");
        wr(5'h1C, 32'hFFFF_FFFF);
        rd_chk(5'h1C, 32'h0, "rd_unmapped7");
        rd_chk(5'h00, 32'hA5, "dout_after_unmapped");

        key_i[0] = 1'b0; step(3); key_i[0] = 1'b1; step(8);
        chk("glitch_state", 32'(key_state_o), 32'h0);
        rd_chk(5'h10, 32'h0, "glitch_edge");
        key_i[0] = 1'b0; step(8);
        chk("press_state", 32'(key_state_o), 32'h1);
        rd_chk(5'h10, 32'h1, "press_edge");
        key_i[0] = 1'b1; step(10);
        chk("release_state", 32'(key_state_o), 32'h0);
        rd_chk(5'h10, 32'h1, "edge_sticky");

        wr(5'h14, 32'h1);
        step(1);
        chk("irq_on", 32'(irq_o), 32'h1);
        wr(5'h10, 32'h1);
        chk("irq_cleared", 32'(irq_o), 32'h0);
        rd_chk(5'h10, 32'h0, "edge_cleared");

        // Press lands on the same edge as the W1C write: set must win.
        key_i[0] = 1'b0; step(5);
        wr(5'h10, 32'h1);
        rd_chk(5'h10, 32'h1, "edge_set_wins");
        chk("irq_set_wins", 32'(irq_o), 32'h1);
        key_i[0] = 1'b1; step(10);
        wr(5'h10, 32'h3);

        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            pat[i] = wb_ack_o;
        end
        @(posedge clock);
        #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        chk("ack_pattern", 32'(pat), 32'h2A);
        step(2);

        for (int it = 0; it < 2000; it++) begin
            step(1);
            wb_cyc_i = ($urandom % 4) != 0;
            wb_stb_i = ($urandom % 3) != 0;
            wb_we_i  = 1'($urandom);
            wb_adr_i = 5'($urandom);
            wb_dat_i = $urandom;
            if ($urandom % 8 == 0) gpio_i = GW'($urandom);
            for (int k = 0; k < KW; k++) if ($urandom % 6 == 0) key_i[k] = ~key_i[k];
        end
        step(1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        key_i = '1;
        step(12);

        // Reset arrives while a write is pending: it must never be acked.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 5'h00; wb_dat_i = 32'h5A;
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("ack_in_reset", 32'(wb_ack_o), 32'h0);
        end
        @(posedge clock);
        #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        reset = 1'b0;
        step(1);
        chk("post_rst_gpio_o", 32'(gpio_o), 32'h0);
        chk("post_rst_gpio_oe", 32'(gpio_oe), 32'h0);
        chk("post_rst_irq", 32'(irq_o), 32'h0);
        rd_chk(5'h10, 32'h0, "post_rst_edge");
        step(2);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
